looper_ctrl: RTL and testbench
==============================

# looper_ctrl

Mode controller for the drum-loop recorder. It turns debounced record/play/stop buttons into the `rec_en` / `play_en` levels that drive the event-memory block, and generates the shared `sample_tick` timebase. It also runs a metronome count-in before recording and tracks whether a usable loop exists. It sits between the button-input logic and the event memory; its `sample_tick` also feeds that memory.

## Interface
Parameters:
- `TICK_DIV`, default 1000: clk cycles per `sample_tick`; must be ≥2.
- `BEAT_TICKS`, default 250: sample ticks per metronome beat; must be ≥1.
- `BEATS`, default 4: count-in beats before recording starts; must be ≥1.

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `rec_btn`  in  1  debounced record button, level
- `play_btn`  in  1  debounced play button, level
- `stop_btn`  in  1  debounced stop button, level
- `metro_en`  in  1  enables clicks during RECORD/PLAY
- `rec_done`  in  1  memory full / time limit reached, from event memory
- `sample_tick`  out  1  one-cycle pulse every `TICK_DIV` clk cycles
- `rec_en`  out  1  high while in RECORD
- `play_en`  out  1  high while in PLAY
- `click`  out  1  one-cycle metronome pulse
- `loop_valid`  out  1  a loop with ≥1 tick has been recorded
- `state_code`  out  2  IDLE=00, COUNT_IN=01, RECORD=10, PLAY=11

## Operation
- Button edges: each button has a registered previous value. An edge is `btn & !prev`, and it acts on the same clock edge on which `btn` is first sampled high. Held buttons produce one edge only.
- Edge priority when several edges occur in one cycle: stop > rec > play. Only the highest-priority edge acts.
- Tick divider: free-running counter 0..`TICK_DIV`-1. `sample_tick`=1 in the cycle the counter equals `TICK_DIV`-1. The divider runs in all states and is never reset by state changes.
- Beat counter: `tib` (tick-in-beat, 0..`BEAT_TICKS`-1) and `beat` (0..`BEATS`-1). Both are cleared on every entry to COUNT_IN, RECORD or PLAY.
  - On each `sample_tick`, `tib` increments. On wrap, `beat` increments; it saturates outside COUNT_IN.
- `click`=1 in a `sample_tick` cycle with `tib`==0. This applies in COUNT_IN always, and in RECORD/PLAY only when `metro_en`=1.
- FSM transitions:
  - IDLE: stop → stay. rec → COUNT_IN. play → PLAY if `loop_valid`, else stay.
  - COUNT_IN: stop → IDLE. rec → IDLE (cancel). play ignored. On a `sample_tick` with `tib`==`BEAT_TICKS`-1 and `beat`==`BEATS`-1 → RECORD.
  - RECORD: stop or rec → IDLE. play → PLAY. `rec_done`=1 → IDLE; if a button edge occurs in the same cycle, the edge wins.
  - PLAY: stop or play → IDLE. rec → COUNT_IN.
- Record length: a 17-bit `rec_ticks` counter clears on entry to RECORD and increments (saturating) on each `sample_tick` in RECORD. On any exit from RECORD, `loop_valid` ← (`rec_ticks`≠0). Otherwise `loop_valid` holds, except on `rst`.
- Outputs are decoded from the registered state only:
  - `rec_en`=(state==RECORD)
  - `play_en`=(state==PLAY)
  - `state_code`=state

  `rec_en` and `play_en` are never both 1.

## Timing
- Reset: `rst` high at a clk edge forces state IDLE and clears the tick counter, `tib`, `beat`, `rec_ticks`, `loop_valid` and button prev registers. The next cycle shows all outputs 0: `sample_tick`, `rec_en`, `play_en`, `click`, `loop_valid` and `state_code`=00. `rst` mid-RECORD drops `rec_en` in the next cycle and leaves `loop_valid`=0.
- After reset, the first `sample_tick` is in cycle `TICK_DIV`-1 (counting from 0 = first cycle after reset release).
- Latency: a button edge sampled at edge N gives the new state and outputs at cycle N+1 (1 cycle). `rec_done` has the same 1-cycle latency.
- Count-in duration: exactly `BEATS`×`BEAT_TICKS` sample ticks. `rec_en` rises the cycle after the final count-in tick.
- RECORD → PLAY: `rec_en` falls and `play_en` rises on the same cycle boundary. The event memory latches its loop length on the `rec_en` fall.
- `click` always coincides with a `sample_tick` cycle.

## Test plan
1. Reset and divider: `TICK_DIV`=4, hold `rst` 3 cycles, release → all outputs 0. `sample_tick` pulses in cycles 3, 7, 11, … after release, each 1 cycle wide.
2. Full take: `TICK_DIV`=4, `BEAT_TICKS`=3, `BEATS`=2; pulse `rec_btn`.
   - `state_code`=01 next cycle; `click` on the 1st and 4th ticks.
   - After 6 ticks `rec_en`=1, `state_code`=10.
   - Pulse `stop_btn` after 5 RECORD ticks → `rec_en`=0 next cycle, `loop_valid`=1.
3. Play gating and loop: with `loop_valid`=0 pulse `play_btn` → stays IDLE. After step 2, `play_btn` → `play_en`=1. A second `play_btn` → IDLE.
4. Empty take: enter RECORD, pulse `stop_btn` before any `sample_tick` → IDLE with `loop_valid`=0.
5. Priority and `rec_done`:
   - In RECORD, assert `stop_btn` and `play_btn` edges in the same cycle → IDLE.
   - In RECORD, `rec_done`=1 → IDLE, `loop_valid`=1.
   - `rec_btn` edge in PLAY → COUNT_IN with `play_en`=0.
6. Held buttons and mid-op reset: hold `rec_btn` high 20 cycles → exactly one transition. Assert `rst` during COUNT_IN → IDLE, `click` silent, `loop_valid`=0.

Source files
------------

// File: rtl/looper_ctrl.sv
// looper_ctrl: record/play mode FSM with sample-tick divider, metronome count-in and loop-valid tracking
module looper_ctrl #(
    parameter int TICK_DIV   = 1000,
    parameter int BEAT_TICKS = 250,
    parameter int BEATS      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rec_btn,
    input  logic       play_btn,
    input  logic       stop_btn,
    input  logic       metro_en,
    input  logic       rec_done,
    output logic       sample_tick,
    output logic       rec_en,
    output logic       play_en,
    output logic       click,
    output logic       loop_valid,
    output logic [1:0] state_code
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int TW = BEAT_TICKS > 1 ? $clog2(BEAT_TICKS) : 1;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TIB_MAX  = TW'(BEAT_TICKS - 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, COUNT_IN = 2'b01, RECORD = 2'b10, PLAY = 2'b11} state_t;

    state_t          state, nxt;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tib;
    logic [BW-1:0]   beat;
    logic [16:0]     rec_ticks;
    logic [2:0]      btn, prev, edges;
    logic            act_stop, act_rec, act_play, tib_wrap, last_beat, entering;

    assign btn       = {play_btn, rec_btn, stop_btn};
    assign edges     = btn & ~prev;
    // only the highest-priority edge acts: stop > rec > play
    assign act_stop  = edges[0];
    assign act_rec   = edges[1] & ~edges[0];
    assign act_play  = edges[2] & ~|edges[1:0];
    assign tib_wrap  = tib == TIB_MAX;
    assign last_beat = beat == BEAT_MAX;
    assign entering  = nxt != state && nxt != IDLE;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = act_rec ? COUNT_IN : (act_play && loop_valid) ? PLAY : IDLE;
            COUNT_IN: nxt = (act_stop || act_rec) ? IDLE
                          : (sample_tick && tib_wrap && last_beat) ? RECORD : COUNT_IN;
            RECORD:   nxt = (act_stop || act_rec) ? IDLE : act_play ? PLAY : rec_done ? IDLE : RECORD;
            PLAY:     nxt = (act_stop || act_play) ? IDLE : act_rec ? COUNT_IN : PLAY;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tib        <= '0;
            beat       <= '0;
            rec_ticks  <= '0;
            loop_valid <= 1'b0;
            prev       <= '0;
        end else begin
            state <= nxt;
            prev  <= btn;
            cnt   <= sample_tick ? '0 : cnt + CW'(1);
            if (entering) begin
                tib  <= '0;
                beat <= '0;
            end else if (sample_tick) begin
                tib <= tib_wrap ? '0 : tib + TW'(1);
                if (tib_wrap && !(last_beat && state != COUNT_IN))
                    beat <= last_beat ? '0 : beat + BW'(1);
            end
            if (nxt == RECORD && state != RECORD)
                rec_ticks <= '0;
            else if (state == RECORD && sample_tick && rec_ticks != '1)
                rec_ticks <= rec_ticks + 17'd1;
            if (state == RECORD && nxt != RECORD)
                loop_valid <= rec_ticks != '0;
        end
    end

    assign sample_tick = cnt == CNT_MAX;
    assign rec_en      = state == RECORD;
    assign play_en     = state == PLAY;
    assign state_code  = state;
    assign click       = sample_tick && tib == '0 &&
                         (state == COUNT_IN || (metro_en && (state == RECORD || state == PLAY)));
endmodule

// File: tb/tb_looper_ctrl.sv
// tb_looper_ctrl: directed scoreboard bench for looper_ctrl with TICK_DIV=4, BEAT_TICKS=3, BEATS=2
module tb_looper_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic [2:0] b = '0;
    logic       metro_en = 1'b0, rec_done = 1'b0;
    logic       sample_tick, rec_en, play_en, click, loop_valid;
    logic [1:0] state_code;
    logic [6:0] obs;
    int         checks = 0, failures = 0, t = 0;

    localparam logic [6:0] M_ALL = 7'h7f, M_TK = 7'h40, M_REC = 7'h20, M_PLAY = 7'h10;
    localparam logic [6:0] M_CLK = 7'h08, M_LV = 7'h04, M_ST = 7'h03;

    typedef struct {string tag; logic [6:0] mask; logic [6:0] val;} exp_t;
    exp_t sb[$];

    looper_ctrl #(.TICK_DIV(4), .BEAT_TICKS(3), .BEATS(2)) dut (
        .clk(clk), .rst(rst), .rec_btn(b[1]), .play_btn(b[2]), .stop_btn(b[0]),
        .metro_en(metro_en), .rec_done(rec_done), .sample_tick(sample_tick),
        .rec_en(rec_en), .play_en(play_en), .click(click), .loop_valid(loop_valid),
        .state_code(state_code)
    );

    always #5 clk = ~clk;
    assign obs = {sample_tick, rec_en, play_en, click, loop_valid, state_code};

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic expect_out(input string tag, input logic [6:0] mask, input logic [6:0] val);
        sb.push_back('{tag, mask, val});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs & e.mask, e.val & e.mask);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        t++;
        drain();
    endtask

    // advance to the next cycle whose divider phase is TICK_DIV-1 and check it there
    task automatic next_tick(input string tag, input logic [6:0] mask, input logic [6:0] val);
        int n;
        n = (t % 4 == 3) ? 4 : 3 - t % 4;
        repeat (n - 1) cyc();
        expect_out(tag, mask | M_TK, val | M_TK);
        cyc();
    endtask

    task automatic align();
        while (t % 4 != 0) cyc();
    endtask

    task automatic press(input int i, input string tag, input logic [6:0] mask, input logic [6:0] val);
        b[i] = 1'b1;
        expect_out(tag, mask, val);
        cyc();
        b[i] = 1'b0;
        cyc();
    endtask

    task automatic countin();
        align();
        press(1, "ci_enter", M_ST | M_REC, 7'h01);
        for (int k = 0; k < 6; k++)
            next_tick("ci_click", M_CLK | M_ST, ((k == 0 || k == 3) ? 7'h08 : 7'h00) | 7'h01);
        expect_out("rec_start", M_ST | M_REC | M_PLAY, 7'h22);
        cyc();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        expect_out("reset", M_ALL, 7'h00);
        drain();
        for (int k = 1; k <= 12; k++) begin
            expect_out("divider", M_TK | M_ST | M_CLK, (k % 4 == 3) ? 7'h40 : 7'h00);
            cyc();
        end
        press(2, "play_gate", M_ST | M_PLAY, 7'h00);
        countin();
        for (int k = 0; k < 5; k++) next_tick("rec_tick", M_REC | M_ST | M_CLK, 7'h22);
        cyc();
        press(0, "take_stop", M_ALL, 7'h04);
        metro_en = 1'b1;
        align();
        press(2, "play_on", M_ST | M_PLAY | M_REC, 7'h13);
        next_tick("play_click", M_CLK | M_PLAY, 7'h18);
        next_tick("play_noclick", M_CLK | M_PLAY, 7'h10);
        press(2, "play_off", M_ST | M_PLAY | M_LV, 7'h04);
        metro_en = 1'b0;
        press(2, "play_again", M_ST | M_PLAY, 7'h13);
        press(1, "play_to_ci", M_ST | M_PLAY | M_REC, 7'h01);
        press(1, "ci_cancel", M_ST | M_LV, 7'h04);
        countin();
        press(0, "empty_take", M_ALL & ~M_TK, 7'h00);
        countin();
        next_tick("rd_tick", M_REC, 7'h20);
        cyc();
        rec_done = 1'b1;
        expect_out("rec_done", M_ST | M_REC | M_LV, 7'h04);
        cyc();
        rec_done = 1'b0;
        cyc();
        countin();
        next_tick("rdp_tick", M_REC, 7'h20);
        cyc();
        rec_done = 1'b1;
        b[2] = 1'b1;
        expect_out("done_vs_play", M_ST | M_PLAY | M_REC, 7'h13);
        cyc();
        rec_done = 1'b0;
        b[2] = 1'b0;
        cyc();
        press(2, "play_exit", M_ST | M_PLAY, 7'h00);
        countin();
        next_tick("sp_tick", M_REC, 7'h20);
        cyc();
        b = 3'b101;
        expect_out("stop_vs_play", M_ST | M_PLAY | M_REC | M_LV, 7'h04);
        cyc();
        b = '0;
        cyc();
        align();
        b[1] = 1'b1;
        expect_out("held_enter", M_ST, 7'h01);
        cyc();
        repeat (19) begin
            expect_out("held", M_ST, 7'h01);
            cyc();
        end
        b[1] = 1'b0;
        rst = 1'b1;
        expect_out("rst_ci", M_ALL, 7'h00);
        cyc();
        rst = 1'b0;
        t = 0;
        for (int k = 1; k <= 8; k++) begin
            expect_out("post_rst", M_ALL, (k % 4 == 3) ? 7'h40 : 7'h00);
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
